// File: rtl/led_frame_ram_pkg.sv
// Shared system state codes, clock constant and stroke FSM encoding for the
// LED frame RAM and its neighbours.
package led_frame_ram_pkg;

  localparam logic [3:0] SYS_IDLE  = 4'h0;
  localparam logic [3:0] SYS_VIEW  = 4'h1;
  localparam logic [3:0] SYS_DRAW  = 4'h2;
  localparam logic [3:0] SYS_ERASE = 4'h3;
  localparam logic [3:0] SYS_SCAN  = 4'h4;

  localparam int CLOCK_FREQ = 50_000_000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2
  } stroke_e;

endpackage

// File: rtl/led_frame_ram_onehot_decode.sv
// One-hot to binary decoder; valid is high only when exactly one bit is set.
module onehot_decode #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] oh,
  output logic [W-1:0] bin,
  output logic         valid
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) bin = bin | W'(i);
    end
  end

  assign valid = (oh != '0) && ((oh & (oh - 1'b1)) == '0);

endmodule

// File: rtl/led_frame_ram.sv
// ROWS x COLS pixel frame store with pen stroke buffering, bulk clear and a
// registered scan read port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no stroke buffered
// S_COLLECT | hits on row_buf accumulate in mask; timer counts idle cycles
// S_COMMIT  | write data_buf to every masked column of row_buf this cycle
module led_frame_ram
  import led_frame_ram_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int DW      = 4,
  parameter int TIMEOUT = CLOCK_FREQ,
  localparam int RW     = $clog2(ROWS),
  localparam int CW     = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      state,
  input  logic [DW-1:0]   data,
  input  logic [ROWS-1:0] addr_row,
  input  logic [COLS-1:0] addr_col,
  input  logic            we,
  input  logic            clr,
  input  logic [RW-1:0]   rd_row,
  input  logic [CW-1:0]   rd_col,
  output logic [DW-1:0]   rd_data,
  output logic [RW-1:0]   last_row,
  output logic [CW-1:0]   last_col,
  output logic            busy,
  output logic            addr_err
);

  localparam int N  = ROWS * COLS;
  localparam int AW = RW + CW;
  localparam int TW = $clog2(TIMEOUT);

  logic [DW-1:0]   ram [N];

  logic            we_d;
  logic [3:0]      state_q;
  stroke_e         fsm, fsm_nxt;
  logic [RW-1:0]   row_buf, row_buf_nxt;
  logic [DW-1:0]   data_buf, data_buf_nxt;
  logic [COLS-1:0] mask, mask_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [AW-1:0]   clr_cnt;

  logic [RW-1:0]   row_bin;
  logic [CW-1:0]   col_bin;
  logic            row_ok, col_ok;
  logic            draw, state_chg, rise, fall, act_edge, addr_ok;
  logic            hit, nd_wr, stroke_wr, addr_err_nxt;
  logic [CW-1:0]   hi_col;

  onehot_decode #(.N(ROWS)) u_row_dec (.oh(addr_row), .bin(row_bin), .valid(row_ok));
  onehot_decode #(.N(COLS)) u_col_dec (.oh(addr_col), .bin(col_bin), .valid(col_ok));

  assign draw         = (state == SYS_DRAW);
  assign state_chg    = (state != state_q);
  assign rise         = we & ~we_d;
  assign fall         = ~we & we_d;
  assign act_edge     = draw ? rise : fall;
  assign addr_ok      = row_ok & col_ok;
  assign hit          = draw & rise & ~busy & addr_ok & ~state_chg;
  assign nd_wr        = ~draw & fall & ~busy & addr_ok & ~state_chg;
  assign addr_err_nxt = act_edge & ~busy & ~addr_ok;

  always_comb begin
    hi_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (mask[c]) hi_col = CW'(c);
    end
  end

  always_comb begin
    fsm_nxt      = fsm;
    row_buf_nxt  = row_buf;
    data_buf_nxt = data_buf;
    mask_nxt     = mask;
    timer_nxt    = timer;
    stroke_wr    = 1'b0;
    if (busy || state_chg || !draw) begin
      fsm_nxt   = S_IDLE;
      mask_nxt  = '0;
      timer_nxt = '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (hit) begin
            fsm_nxt      = S_COLLECT;
            row_buf_nxt  = row_bin;
            data_buf_nxt = data;
            mask_nxt     = addr_col;
            timer_nxt    = '0;
          end
        end
        S_COLLECT: begin
          if (hit && row_bin == row_buf) begin
            mask_nxt  = mask | addr_col;
            timer_nxt = '0;
            if (&(mask | addr_col)) fsm_nxt = S_COMMIT;
          end else if (hit) begin
            // hit on another row flushes the old stroke in the same cycle
            stroke_wr    = 1'b1;
            row_buf_nxt  = row_bin;
            data_buf_nxt = data;
            mask_nxt     = addr_col;
            timer_nxt    = '0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            fsm_nxt = S_COMMIT;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        S_COMMIT: begin
          stroke_wr = 1'b1;
          fsm_nxt   = S_IDLE;
          mask_nxt  = '0;
          if (hit) begin
            fsm_nxt      = S_COLLECT;
            row_buf_nxt  = row_bin;
            data_buf_nxt = data;
            mask_nxt     = addr_col;
            timer_nxt    = '0;
          end
        end
        default: begin
          fsm_nxt  = S_IDLE;
          mask_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_d     <= 1'b0;
      state_q  <= SYS_IDLE;
      fsm      <= S_IDLE;
      row_buf  <= '0;
      data_buf <= '0;
      mask     <= '0;
      timer    <= '0;
      busy     <= 1'b0;
      clr_cnt  <= '0;
      addr_err <= 1'b0;
      last_row <= '0;
      last_col <= '0;
      rd_data  <= '0;
    end else begin
      we_d     <= we;
      state_q  <= state;
      fsm      <= fsm_nxt;
      row_buf  <= row_buf_nxt;
      data_buf <= data_buf_nxt;
      mask     <= mask_nxt;
      timer    <= timer_nxt;
      addr_err <= addr_err_nxt;
      rd_data  <= ram[{rd_row, rd_col}];

      if (busy) begin
        if (clr_cnt == AW'(N - 1)) busy <= 1'b0;
        else                       clr_cnt <= clr_cnt + 1'b1;
      end else if (clr) begin
        busy    <= 1'b1;
        clr_cnt <= '0;
      end

      if (state_chg) begin
        last_row <= '0;
        last_col <= '0;
      end else if (nd_wr) begin
        last_row <= row_bin;
        last_col <= col_bin;
      end else if (stroke_wr) begin
        last_row <= row_buf;
        last_col <= hi_col;
      end
    end
  end

  // frame contents survive reset; only the clear engine zeroes them
  always_ff @(posedge clk) begin
    if (busy) begin
      ram[clr_cnt] <= '0;
    end else if (nd_wr) begin
      ram[{row_bin, col_bin}] <= data;
    end else if (stroke_wr) begin
      for (int c = 0; c < COLS; c++) begin
        if (mask[c]) ram[{row_buf, CW'(c)}] <= data_buf;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_ram.sv
// Directed-plus-random bench for led_frame_ram with a frame-level reference model.
module tb_led_frame_ram;
  import led_frame_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = SYS_VIEW;
  logic [3:0] data = '0;
  logic [7:0] addr_row = '0;
  logic [7:0] addr_col = '0;
  logic       we = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] rd_row = '0;
  logic [2:0] rd_col = '0;
  logic [3:0] rd_data;
  logic [2:0] last_row;
  logic [2:0] last_col;
  logic       busy;
  logic       addr_err;

  logic [3:0] m [64];
  int passed = 0;
  int fails = 0;

  led_frame_ram #(.ROWS(8), .COLS(8), .DW(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .data(data),
    .addr_row(addr_row), .addr_col(addr_col), .we(we), .clr(clr),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .last_row(last_row), .last_col(last_col), .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_last(input string tag, input int r, input int c);
    chk({tag, "_row"}, 32'(last_row), 32'(r));
    chk({tag, "_col"}, 32'(last_col), 32'(c));
  endtask

  task automatic rd_chk(input string tag, input int r, input int c);
    rd_row = 3'(r);
    rd_col = 3'(c);
    tick();
    chk(tag, 32'(rd_data), 32'(m[r*8+c]));
  endtask

  // rising edge of we on (r,c); we is lowered but the caller owns the next tick
  task automatic pen(input int r, input int c, input logic [3:0] d);
    addr_row = 8'(1 << r);
    addr_col = 8'(1 << c);
    data = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic pen_nd(input int r, input int c, input logic [3:0] d);
    pen(r, c, d);
    tick();
    m[r*8+c] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m[i] = '0;
  endtask

  initial begin
    int n, r, c, perm[8], tmp, j;
    logic [3:0] d, d2, old;
    logic err_seen;

    // reset values
    cyc(2);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk_last("rst_last", 0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr_err", 32'(addr_err), 0);
    rst_n = 1'b1;
    cyc(2);

    // initial clear establishes known frame contents
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk("clr0_busy_cycles", 32'(n), 64);
    model_clear();

    // non-DRAW directed write and read-back
    pen_nd(2, 4, 4'hA);
    chk_last("nd_last", 2, 4);
    rd_chk("nd_rd_2_4", 2, 4);

    // non-DRAW random writes
    for (int k = 0; k < 6; k++) begin
      r = int'($urandom_range(7, 0));
      c = int'($urandom_range(7, 0));
      d = 4'($urandom);
      pen_nd(r, c, d);
      chk_last("nd_rand_last", r, c);
      rd_chk("nd_rand_rd", r, c);
    end

    // same-cycle read returns the old value
    old = m[6*8+6];
    d = old ^ 4'h5;
    rd_row = 3'd6;
    rd_col = 3'd6;
    pen(6, 6, d);
    tick();
    chk("rdw_old", 32'(rd_data), 32'(old));
    m[6*8+6] = d;
    tick();
    chk("rdw_new", 32'(rd_data), 32'(d));
    chk_last("rdw_last", 6, 6);

    // invalid column address on a falling edge
    addr_row = 8'h02;
    addr_col = 8'h03;
    data = 4'hF;
    we = 1'b1;
    tick();
    we = 1'b0;
    tick();
    chk("inv_addr_err_hi", 32'(addr_err), 1);
    tick();
    chk("inv_addr_err_lo", 32'(addr_err), 0);
    chk_last("inv_last", 6, 6);
    rd_chk("inv_rd_1_0", 1, 0);
    rd_chk("inv_rd_1_1", 1, 1);

    // enter DRAW: last_* cleared on state change
    state = SYS_DRAW;
    tick();
    chk_last("draw_enter_last", 0, 0);

    // DRAW timeout stroke on row 3
    d = 4'($urandom);
    rd_row = 3'd3;
    rd_col = 3'd6;
    pen(3, 1, d);
    cyc(3);
    old = m[3*8+6];
    pen(3, 6, ~d);
    cyc(16);
    chk_last("to_before", 0, 0);
    tick();
    chk_last("to_commit", 3, 6);
    chk("to_rd_old", 32'(rd_data), 32'(old));
    m[3*8+1] = d;
    m[3*8+6] = d;
    tick();
    chk("to_rd_new", 32'(rd_data), 32'(d));
    rd_chk("to_rd_3_1", 3, 1);
    rd_chk("to_rd_3_0", 3, 0);

    // DRAW full row 5 in random column order
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    d = 4'($urandom);
    for (int i = 0; i < 8; i++) begin
      pen(5, perm[i], (i == 0) ? d : 4'($urandom));
      if (i < 7) tick();
    end
    chk_last("row_before", 3, 6);
    tick();
    chk_last("row_commit", 5, 7);
    for (int i = 0; i < 8; i++) m[5*8+i] = d;
    for (int i = 0; i < 8; i++) rd_chk("row_rd", 5, i);

    // DRAW row change flushes the first stroke in the hit cycle
    d = 4'($urandom);
    d2 = 4'($urandom);
    pen(1, 2, d);
    tick();
    pen(4, 0, d2);
    chk_last("rc_flush", 1, 2);
    m[1*8+2] = d;
    cyc(16);
    chk_last("rc_wait", 1, 2);
    tick();
    chk_last("rc_commit", 4, 0);
    m[4*8+0] = d2;
    rd_chk("rc_rd_1_2", 1, 2);
    rd_chk("rc_rd_4_0", 4, 0);

    // hit in the COMMIT cycle is kept as a new stroke
    d = 4'($urandom);
    d2 = ~d;
    pen(6, 3, d);
    cyc(16);
    pen(6, 5, d2);
    chk_last("cc_first", 6, 3);
    m[6*8+3] = d;
    cyc(16);
    tick();
    chk_last("cc_second", 6, 5);
    m[6*8+5] = d2;
    rd_chk("cc_rd_6_3", 6, 3);
    rd_chk("cc_rd_6_5", 6, 5);

    // invalid row address on a DRAW rising edge starts no stroke
    addr_row = 8'h00;
    addr_col = 8'h01;
    we = 1'b1;
    tick();
    we = 1'b0;
    chk("draw_inv_err", 32'(addr_err), 1);
    cyc(20);
    chk_last("draw_inv_last", 6, 5);

    // state change mid-stroke discards the buffer
    d = m[2*8+2] ^ 4'hC;
    pen(2, 2, d);
    cyc(3);
    state = SYS_VIEW;
    tick();
    chk_last("sc_last", 0, 0);
    cyc(20);
    chk_last("sc_last_later", 0, 0);
    rd_chk("sc_rd_2_2", 2, 2);

    // clear after writes, with ignored we pulses and a repeated clr
    pen_nd(7, 3, 4'($urandom));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    err_seen = 1'b0;
    while (busy && n < 200) begin
      n++;
      clr = (n == 10);
      if (n < 60) begin
        we = n[0];
        addr_row = 8'(1 << (n % 8));
        addr_col = (n % 4 == 1) ? 8'h03 : 8'(1 << ((n + 3) % 8));
        data = 4'($urandom);
      end else begin
        we = 1'b0;
      end
      err_seen |= addr_err;
      tick();
    end
    clr = 1'b0;
    chk("clr_busy_cycles", 32'(n), 64);
    chk("clr_no_addr_err", 32'(err_seen), 0);
    chk_last("clr_last", 7, 3);
    model_clear();
    for (int i = 0; i < 64; i++) rd_chk("clr_rd_zero", i / 8, i % 8);

    // reset during a clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cyc(10);
    chk("mid_clr_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk_last("rst_mid_last", 0, 0);
    chk("rst_mid_rd_data", 32'(rd_data), 0);
    chk("rst_mid_addr_err", 32'(addr_err), 0);
    cyc(2);
    chk("rst_hold_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", passed, passed + fails);
    $finish;
  end

endmodule
